// File: rtl/gprs_wr_sched.sv
// Write-port scheduler for the single-write-port register file: arbitrates WB,
// late (long-latency) and debug writes and tracks pending late results for DEC hazards.
module gprs_wr_sched #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_WIDTH   = 5,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  wb_valid,
  input  logic [RD_WIDTH-1:0]   wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_hold,
  input  logic                  late_valid,
  input  logic [RD_WIDTH-1:0]   late_rd,
  input  logic [DATA_WIDTH-1:0] late_data,
  output logic                  late_ready,
  input  logic                  dbg_valid,
  input  logic [RD_WIDTH-1:0]   dbg_rd,
  input  logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  dbg_ready,
  input  logic                  issue_valid,
  input  logic [RD_WIDTH-1:0]   issue_rd,
  input  logic [RD_WIDTH-1:0]   rs1_dec,
  input  logic [RD_WIDTH-1:0]   rs2_dec,
  input  logic [RD_WIDTH-1:0]   rd_dec,
  output logic                  hazard,
  output logic                  sb_empty,
  output logic                  wr_valid,
  output logic [RD_WIDTH-1:0]   rd_wb,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  proto_err
);

  localparam int unsigned NREG = 1 << RD_WIDTH;
  localparam int unsigned CW   = $clog2(MAX_WAIT + 1);

  logic            rr_q, rr_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            wb_hold_q, wb_hold_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            proto_err_q, proto_err_d;

  logic dbg_xfer, late_xfer;
  logic req_any, blocked;

  // Arbitration and register-file write mux; WB always wins, rr breaks dbg/late ties
  always_comb begin
    dbg_ready  = !wb_valid && (!late_valid || !rr_q);
    late_ready = !wb_valid && (!dbg_valid || rr_q);
    dbg_xfer   = dbg_valid && dbg_ready;
    late_xfer  = late_valid && late_ready;
    wr_valid   = 1'b0;
    rd_wb      = '0;
    wr_data    = '0;
    if (wb_valid) begin
      wr_valid = (wb_rd != '0);
      rd_wb    = wb_rd;
      wr_data  = wb_data;
    end else if (dbg_xfer) begin
      wr_valid = (dbg_rd != '0);
      rd_wb    = dbg_rd;
      wr_data  = dbg_data;
    end else if (late_xfer) begin
      wr_valid = (late_rd != '0);
      rd_wb    = late_rd;
      wr_data  = late_data;
    end
  end

  // Round-robin pointer flips to the other side after each dbg/late transfer
  always_comb begin
    rr_d = rr_q;
    if (dbg_xfer)       rr_d = 1'b1;
    else if (late_xfer) rr_d = 1'b0;
  end

  // Starvation guard: after MAX_WAIT blocked cycles, force one WB bubble
  always_comb begin
    req_any    = dbg_valid || late_valid;
    blocked    = req_any && wb_valid;
    wait_cnt_d = wait_cnt_q;
    if (dbg_xfer || late_xfer || !req_any || wb_hold_q) begin
      wait_cnt_d = '0;
    end else if (blocked && (wait_cnt_q != CW'(MAX_WAIT))) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
    wb_hold_d = blocked && !wb_hold_q && (wait_cnt_q == CW'(MAX_WAIT - 1));
  end

  // Pending late-write scoreboard; a same-cycle set beats the clear
  always_comb begin
    busy_d = busy_q;
    if (late_xfer) busy_d[late_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Reissue to a register whose late result retires this same cycle is legal
  always_comb begin
    proto_err_d = proto_err_q;
    if (wb_valid && wb_hold_q) proto_err_d = 1'b1;
    if (issue_valid && (issue_rd != '0) && busy_q[issue_rd] &&
        !(late_xfer && (late_rd == issue_rd))) proto_err_d = 1'b1;
    if (late_xfer && !busy_q[late_rd]) proto_err_d = 1'b1;
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      rr_q        <= 1'b0;
      wait_cnt_q  <= '0;
      wb_hold_q   <= 1'b0;
      busy_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      wait_cnt_q  <= wait_cnt_d;
      wb_hold_q   <= wb_hold_d;
      busy_q      <= busy_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign wb_hold   = wb_hold_q;
  assign proto_err = proto_err_q;
  assign hazard    = busy_q[rs1_dec] | busy_q[rs2_dec] | busy_q[rd_dec];
  assign sb_empty  = (busy_q == '0);

endmodule

// File: doc/gprs_wr_sched.md
Name: gprs_wr_sched

Overview:
- Write-port scheduler for the core register file, which has a single write port.
- Shares that port between three requesters: pipeline WB, the long-latency unit (mul/div/load-miss late writeback) and debug register writes.
- Keeps a pending-write scoreboard for late results and raises DEC-stage hazards from it.
- Drives the register file's wr_valid/rd_wb/wr_data inputs directly, combinationally.

Parameters:
DATA_WIDTH, 32, register data width
RD_WIDTH, 5, register index width
MAX_WAIT, 4, cycles a dbg/late request may be blocked by WB before a WB bubble is forced (>=1)

Ports:
cpu_clk  input  1  core clock
cpu_rst  input  1  asynchronous reset, active-high
wb_valid  input  1  WB-stage write request; not back-pressured
wb_rd  input  RD_WIDTH  WB destination
wb_data  input  DATA_WIDTH  WB data
wb_hold  output  1  registered; core must not assert wb_valid in a cycle where this is 1
late_valid  input  1  long-latency result valid
late_rd  input  RD_WIDTH  late destination
late_data  input  DATA_WIDTH  late data
late_ready  output  1  late result accepted this cycle
dbg_valid  input  1  debug write request
dbg_rd  input  RD_WIDTH  debug destination
dbg_data  input  DATA_WIDTH  debug data
dbg_ready  output  1  debug write accepted this cycle
issue_valid  input  1  DEC dispatches a long-latency op
issue_rd  input  RD_WIDTH  its destination
rs1_dec, rs2_dec, rd_dec  input  RD_WIDTH each  DEC operand and destination indices
hazard  output  1  DEC must stall
sb_empty  output  1  no late write pending
wr_valid  output  1  register file write enable
rd_wb  output  RD_WIDTH  register file write index
wr_data  output  DATA_WIDTH  register file write data
proto_err  output  1  sticky protocol-error flag

Behaviour:
- Reset (cpu_rst=1, asynchronous): busy[31:1]=0, rr=0, wait_cnt=0, wb_hold=0, proto_err=0. Pending scoreboard entries are discarded; reset mid-operation needs no drain.
- Grant priority each cycle (combinational):
  - wb_valid always wins.
  - Otherwise choose between dbg and late by rr: rr=0 prefers dbg, rr=1 prefers late.
  - A lone requester is granted immediately.
- dbg_ready = !wb_valid && dbg_valid-grant-eligible, i.e. (!late_valid || rr==0). late_ready = !wb_valid && (!dbg_valid || rr==1). Both ready outputs may be high with no valid present (with all valids low after reset, dbg_ready=1).
- A transfer occurs when valid && ready. After a dbg or late transfer, rr is set to point at the other requester. WB grants do not change rr.
- Write output:
  - wr_valid = granted && granted_rd!=0.
  - rd_wb and wr_data come from the granted source; they are 0 when nothing is granted.
  - Writes to x0 are still handshaked (ready=1) but produce no wr_valid.
  - Zero added latency: the register file captures the write on the same cpu_clk edge as the handshake.
- Starvation counter (width $clog2(MAX_WAIT+1)):
  - Increments, saturating, on each cycle where (dbg_valid||late_valid) && wb_valid.
  - Clears on any dbg/late transfer, or when neither dbg_valid nor late_valid is asserted.
  - When wait_cnt==MAX_WAIT-1 and the block condition holds, wb_hold=1 next cycle for exactly one cycle, then wait_cnt clears.
  - In the wb_hold cycle the blocked requester is granted.
- Scoreboard:
  - issue_valid && issue_rd!=0 sets busy[issue_rd].
  - A late transfer clears busy[late_rd].
  - Same-cycle set and clear of the same index: set wins.
  - Debug writes do not touch busy.
- hazard = busy[rs1_dec] | busy[rs2_dec] | busy[rd_dec] (WAW check); index 0 is never busy. hazard is combinational from registered busy, so a register cleared this cycle is visible to DEC next cycle.
- sb_empty = (busy==0).
- proto_err is set, sticky until reset, on any of:
  - wb_valid while wb_hold=1 (WB still wins);
  - issue to an already-busy rd;
  - a late transfer to a non-busy rd (the write is still performed).

Test Plan:
- Reset, then dbg_valid with dbg_rd=5, dbg_data=0xA5A5_0001 -> same cycle dbg_ready=1, wr_valid=1, rd_wb=5, wr_data=0xA5A5_0001; rr becomes 1.
- dbg and late valid together (rd 3 and 4), no WB, held for 2 cycles -> dbg granted cycle 1, late granted cycle 2 (alternation); wr_valid both cycles.
- issue_rd=7, then rs1_dec=7 -> hazard=1 and sb_empty=0 from the next cycle; late write to rd 7 -> hazard=0 and sb_empty=1 the cycle after the transfer.
- late_valid held while wb_valid continuous, MAX_WAIT=4 -> wb_hold=1 in the 5th cycle; late granted that cycle; wait_cnt back to 0.
- wb_valid asserted during wb_hold -> WB write wins and proto_err=1 stays set until cpu_rst.
- dbg write to x0 -> dbg_ready=1, wr_valid=0. Same-cycle issue_rd=9 and late write rd=9 with busy[9]=1 -> busy[9] remains 1, no proto_err.
